blink_seq_ctrl: RTL and testbench
=================================

Name: blink_seq_ctrl

Overview:
- Sequencing controller for the RGB LED blink datapath: owns the run/stop/demo mode, the blink speed setting, the clock prescaler and the 5-step pattern index.
- Consumes two debounced one-cycle button pulses and drives the step index to the LED decoder.
- Sits between the debounce instances and the LED pattern decoder in the top level. The top level supplies a synchronized reset.

Parameters:
- BASE_W, 27, prescaler width; slowest tick period is 2^BASE_W cycles; legal range BASE_W >= 4
- NSTEP, 5, pattern length; STEP counts 0..NSTEP-1; legal range 2..8

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- BTN_MODE  input  1  debounced one-cycle pulse; advances the operating mode
- BTN_NEXT  input  1  debounced one-cycle pulse; single-step (STOP) or speed+1 (RUN)
- SPEED  output  2  current speed, 0 = slowest, 3 = fastest
- STEP  output  3  pattern index, 0..NSTEP-1
- TICK  output  1  step-advance strobe, one cycle wide
- RUN  output  1  high in RUN or DEMO
- DEMO  output  1  high in DEMO

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high. All state is cleared immediately on RST assertion.
- Reset values: state = STOP, SPEED = 0, STEP = 0, prescaler = 0, TICK = 0, RUN = 0, DEMO = 0.
- Reset asserted mid-operation returns every register to its reset value. No pending pulse survives reset.
- FSM transitions, driven by BTN_MODE only: STOP -> RUN -> DEMO -> STOP. The transition happens on the edge where BTN_MODE = 1.
- RUN and DEMO are registered decodes of state. They change one cycle after the BTN_MODE edge.
- Priority: BTN_MODE and BTN_NEXT high in the same cycle -> the mode change is taken and BTN_NEXT is dropped.
- Prescaler:
  - BASE_W-bit up-counter; wraps naturally.
  - Held at 0 while in STOP.
  - Counts every cycle in RUN and DEMO, starting from 0 on entry from STOP.
  - Not cleared on RUN -> DEMO.
- TICK:
  - Combinational.
  - Equals 1 when state != STOP and prescaler bits [BASE_W-1-SPEED : 0] are all ones.
  - Tick period is 2^(BASE_W-SPEED) cycles.
  - A SPEED change takes effect on the next cycle's comparison; the prescaler is not reset on a speed change.
- STEP:
  - RUN/DEMO: increments on each edge with TICK = 1; wraps NSTEP-1 -> 0.
  - STOP: increments on each edge with BTN_NEXT = 1 (and BTN_MODE = 0), same wrap rule.
- SPEED:
  - RUN: BTN_NEXT increments SPEED mod 4 (3 -> 0).
  - DEMO: BTN_NEXT is ignored. SPEED increments mod 4 on the edge where TICK = 1 and STEP = NSTEP-1, i.e. on the same edge as the STEP wrap.
  - STOP: SPEED holds.
- Mode exits:
  - DEMO -> STOP retains SPEED and STEP.
  - STOP -> RUN retains SPEED and STEP.
- BTN inputs are assumed to be one-cycle pulses. A multi-cycle high is treated as one event per cycle; no edge detection is performed inside the block.
- Latency: STEP, SPEED and state change on the clock edge that samples the qualifying event. TICK is same-cycle combinational.

Test Plan (BASE_W = 6, NSTEP = 5 unless noted):
- Reset: pulse RST mid-count while in DEMO with SPEED = 2 and STEP = 3 -> all outputs 0 immediately, state STOP; prescaler stays 0 for 20 idle cycles.
- Tick rate: BTN_MODE once (RUN), SPEED = 0 -> TICK every 64 cycles with first TICK 64 cycles after entry. Three BTN_NEXT pulses -> SPEED = 3, TICK every 8 cycles; STEP sequence 0,1,2,3,4,0.
- Speed wrap and mid-count change: in RUN, four BTN_NEXT pulses -> SPEED 1,2,3,0. A change from SPEED 0 to 3 when prescaler = 5 -> next TICK at prescaler = 7.
- Single-step: in STOP, three BTN_NEXT pulses -> STEP = 3, TICK never asserts, SPEED unchanged. Six more pulses -> STEP = 4 then wraps to 0 (nine pulses total -> STEP = 4).
- Demo auto-speed: enter DEMO with SPEED = 0, STEP = 0 -> after 5 ticks (320 cycles) SPEED = 1 on the wrap edge. After a further 5 ticks at 32-cycle period, SPEED = 2. BTN_NEXT during DEMO leaves SPEED unchanged.
- Simultaneous pulses: BTN_MODE and BTN_NEXT in the same cycle in RUN -> state becomes DEMO, SPEED unchanged. Repeat in STOP -> state becomes RUN, STEP unchanged.

Source files
------------

// File: rtl/blink_seq_ctrl_if.sv
// rtl/blink_seq_ctrl_if.sv - button pulse inputs and sequencing outputs of blink_seq_ctrl
//
// Signals:
//   BTN_MODE  debounced one-cycle pulse, advances STOP -> RUN -> DEMO -> STOP
//   BTN_NEXT  debounced one-cycle pulse, single-step (STOP) or speed+1 (RUN)
//   SPEED     current speed, 0 = slowest, 3 = fastest
//   STEP      pattern index 0..NSTEP-1 for the LED decoder
//   TICK      one-cycle step-advance strobe
//   RUN       high in RUN or DEMO
//   DEMO      high in DEMO
// Modports: master drives the buttons, slave is the controller.

interface blink_seq_ctrl_if;
    logic       BTN_MODE;
    logic       BTN_NEXT;
    logic [1:0] SPEED;
    logic [2:0] STEP;
    logic       TICK;
    logic       RUN;
    logic       DEMO;

    modport master (
        output BTN_MODE, BTN_NEXT,
        input  SPEED, STEP, TICK, RUN, DEMO
    );

    modport slave (
        input  BTN_MODE, BTN_NEXT,
        output SPEED, STEP, TICK, RUN, DEMO
    );
endinterface

// File: rtl/blink_seq_ctrl.sv
// rtl/blink_seq_ctrl.sv - run/stop/demo mode, speed, prescaler and step index for the RGB LED blink path
//
// Ports:
//   CLK  system clock
//   RST  asynchronous active-high reset (synchronized release by the top level)
//   bus  blink_seq_ctrl_if.slave: BTN_MODE/BTN_NEXT in; SPEED/STEP/TICK/RUN/DEMO out
// Parameters:
//   BASE_W  prescaler width, slowest tick period is 2^BASE_W cycles (>= 4)
//   NSTEP   pattern length, STEP counts 0..NSTEP-1 (2..8)

module blink_seq_ctrl #(
    parameter int BASE_W = 27,
    parameter int NSTEP  = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    blink_seq_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEMO = 2'd2
    } state_t;

    localparam logic [2:0]        STEP_LAST = 3'(NSTEP - 1);
    localparam logic [BASE_W-1:0] PRESC_ONE = {{(BASE_W-1){1'b0}}, 1'b1};
    localparam logic [BASE_W-1:0] ALL_ONES  = {BASE_W{1'b1}};

    state_t              r_state;
    logic [BASE_W-1:0]   r_presc;
    logic [1:0]          r_speed;
    logic [2:0]          r_step;
    logic                r_run;
    logic                r_demo;

    state_t              w_state_nxt;
    logic [BASE_W-1:0]   w_presc_nxt;
    logic [1:0]          w_speed_nxt;
    logic [2:0]          w_step_nxt;
    logic [2:0]          w_step_inc;
    logic [BASE_W-1:0]   w_mask;
    logic                w_step_wrap;
    logic                w_tick;

    // Faster speeds compare fewer low prescaler bits, halving the period per speed step.
    assign w_mask      = ALL_ONES >> r_speed;
    assign w_tick      = (r_state != ST_STOP) && ((r_presc & w_mask) == w_mask);
    assign w_step_wrap = (r_step == STEP_LAST);
    assign w_step_inc  = w_step_wrap ? 3'd0 : (r_step + 3'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the datapath updates; BTN_MODE wins over BTN_NEXT in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_step_nxt  = r_step;
        case (r_state)
            ST_STOP: begin
                if (bus.BTN_MODE) begin
                    w_state_nxt = ST_RUN;
                end else if (bus.BTN_NEXT) begin
                    w_step_nxt = w_step_inc;
                end
            end
            ST_RUN: begin
                if (bus.BTN_MODE) begin
                    w_state_nxt = ST_DEMO;
                end else if (bus.BTN_NEXT) begin
                    w_speed_nxt = r_speed + 2'd1;
                end
            end
            ST_DEMO: begin
                if (bus.BTN_MODE) begin
                    w_state_nxt = ST_STOP;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase

        // TICK never fires in STOP, so it cannot collide with single-stepping.
        if (w_tick) begin
            w_step_nxt = w_step_inc;
            if (r_state == ST_DEMO && w_step_wrap) begin
                w_speed_nxt = r_speed + 2'd1;
            end
        end

        // Zero whenever STOP is current or next, so counting restarts from 0 on leaving STOP.
        if (r_state == ST_STOP || w_state_nxt == ST_STOP) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + PRESC_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_presc <= '0;
            r_speed <= 2'd0;
            r_step  <= 3'd0;
            r_run   <= 1'b0;
            r_demo  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_speed <= w_speed_nxt;
            r_step  <= w_step_nxt;
            // Registered decodes of the current state: they trail the mode edge by one cycle.
            r_run   <= (r_state != ST_STOP);
            r_demo  <= (r_state == ST_DEMO);
        end
    end

    assign bus.SPEED = r_speed;
    assign bus.STEP  = r_step;
    assign bus.TICK  = w_tick;
    assign bus.RUN   = r_run;
    assign bus.DEMO  = r_demo;

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// tb/tb_blink_seq_ctrl.sv - directed self-checking bench for blink_seq_ctrl (BASE_W=6, NSTEP=5)

module tb_blink_seq_ctrl;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    blink_seq_ctrl_if bus ();

    blink_seq_ctrl #(.BASE_W(6), .NSTEP(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cycle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        bus.BTN_MODE = 1'b0;
        bus.BTN_NEXT = 1'b0;
        cycle(2);
        RST = 1'b0;
        cycle(1);
    endtask

    task automatic pulse_mode();
        bus.BTN_MODE = 1'b1;
        cycle(1);
        bus.BTN_MODE = 1'b0;
    endtask

    task automatic pulse_next();
        bus.BTN_NEXT = 1'b1;
        cycle(1);
        bus.BTN_NEXT = 1'b0;
    endtask

    task automatic pulse_both();
        bus.BTN_MODE = 1'b1;
        bus.BTN_NEXT = 1'b1;
        cycle(1);
        bus.BTN_MODE = 1'b0;
        bus.BTN_NEXT = 1'b0;
    endtask

    // Cycles until STEP changes; -1 when the budget runs out.
    task automatic wait_step_change(input int budget, output int cycles);
        logic [2:0] prev;
        prev   = bus.STEP;
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            cycle(1);
            if (bus.STEP !== prev) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.BTN_MODE = 1'b0;
        bus.BTN_NEXT = 1'b0;
        #1;
        n_checks++;
        if ({bus.SPEED, bus.STEP, bus.TICK, bus.RUN, bus.DEMO} !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_init: got %b expected 00000000", {bus.SPEED, bus.STEP, bus.TICK, bus.RUN, bus.DEMO});
        end
        cycle(2);
        RST = 1'b0;
        cycle(1);
        // Build DEMO, SPEED=2, STEP=3, then reset mid-count
        pulse_next(); pulse_next(); pulse_next();
        pulse_mode();
        pulse_next(); pulse_next();
        pulse_mode();
        cycle(1);
        n_checks++;
        if (bus.DEMO !== 1'b1 || bus.SPEED !== 2'd2 || bus.STEP !== 3'd3) begin
            n_errors++;
            $display("FAIL reset_setup: got demo=%0d speed=%0d step=%0d expected demo=1 speed=2 step=3", bus.DEMO, bus.SPEED, bus.STEP);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if (bus.SPEED !== 2'd0) begin n_errors++; $display("FAIL reset_speed: got %0d expected 0", bus.SPEED); end
        n_checks++;
        if (bus.STEP !== 3'd0) begin n_errors++; $display("FAIL reset_step: got %0d expected 0", bus.STEP); end
        n_checks++;
        if (bus.TICK !== 1'b0) begin n_errors++; $display("FAIL reset_tick: got %0d expected 0", bus.TICK); end
        n_checks++;
        if (bus.RUN !== 1'b0 || bus.DEMO !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mode: got run=%0d demo=%0d expected 0 0", bus.RUN, bus.DEMO);
        end
        cycle(1);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            n_checks++;
            if (dut.r_presc !== 6'd0 || bus.TICK !== 1'b0 || bus.RUN !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle: cycle %0d got presc=%0d tick=%0d run=%0d expected 0 0 0", i, dut.r_presc, bus.TICK, bus.RUN);
            end
        end
    endtask

    task automatic test_tick_rate();
        int c;
        logic [2:0] exp_step;
        apply_reset();
        pulse_mode();
        wait_step_change(200, c);
        n_checks++;
        if (c !== 64 || bus.STEP !== 3'd1) begin
            n_errors++;
            $display("FAIL tick_first: got cycles=%0d step=%0d expected 64 1", c, bus.STEP);
        end
        wait_step_change(200, c);
        n_checks++;
        if (c !== 64 || bus.STEP !== 3'd2) begin
            n_errors++;
            $display("FAIL tick_period0: got cycles=%0d step=%0d expected 64 2", c, bus.STEP);
        end
        pulse_next(); pulse_next(); pulse_next();
        n_checks++;
        if (bus.SPEED !== 2'd3) begin n_errors++; $display("FAIL tick_speed3: got %0d expected 3", bus.SPEED); end
        wait_step_change(100, c);
        for (int i = 0; i < 6; i++) begin
            exp_step = (bus.STEP == 3'd4) ? 3'd0 : bus.STEP + 3'd1;
            wait_step_change(100, c);
            n_checks++;
            if (c !== 8 || bus.STEP !== exp_step) begin
                n_errors++;
                $display("FAIL tick_period3: iter %0d got cycles=%0d step=%0d expected 8 %0d", i, c, bus.STEP, exp_step);
            end
        end
    endtask

    task automatic test_speed_wrap();
        int c;
        logic [1:0] exp_speed;
        apply_reset();
        pulse_mode();
        exp_speed = 2'd0;
        for (int i = 0; i < 4; i++) begin
            pulse_next();
            exp_speed = exp_speed + 2'd1;
            n_checks++;
            if (bus.SPEED !== exp_speed) begin
                n_errors++;
                $display("FAIL speed_wrap: pulse %0d got %0d expected %0d", i, bus.SPEED, exp_speed);
            end
        end
        // Mid-count speed change: reach SPEED=3 with prescaler at 5
        apply_reset();
        pulse_mode();
        cycle(2);
        pulse_next(); pulse_next(); pulse_next();
        n_checks++;
        if (bus.SPEED !== 2'd3 || dut.r_presc !== 6'd5) begin
            n_errors++;
            $display("FAIL speed_mid_setup: got speed=%0d presc=%0d expected 3 5", bus.SPEED, dut.r_presc);
        end
        c = -1;
        for (int i = 1; i <= 20; i++) begin
            cycle(1);
            if (bus.TICK === 1'b1) begin
                c = i;
                break;
            end
        end
        n_checks++;
        if (c !== 2 || bus.STEP !== 3'd0) begin
            n_errors++;
            $display("FAIL speed_mid_tick: got cycles=%0d step=%0d expected 2 0", c, bus.STEP);
        end
        cycle(1);
        n_checks++;
        if (bus.STEP !== 3'd1) begin n_errors++; $display("FAIL speed_mid_step: got %0d expected 1", bus.STEP); end
    endtask

    task automatic test_single_step();
        logic [2:0] exp_step;
        apply_reset();
        pulse_mode();
        pulse_next();
        pulse_mode();
        pulse_mode();
        cycle(1);
        n_checks++;
        if (bus.RUN !== 1'b0 || bus.SPEED !== 2'd1 || bus.STEP !== 3'd0) begin
            n_errors++;
            $display("FAIL step_setup: got run=%0d speed=%0d step=%0d expected 0 1 0", bus.RUN, bus.SPEED, bus.STEP);
        end
        exp_step = 3'd0;
        for (int i = 1; i <= 9; i++) begin
            pulse_next();
            exp_step = (exp_step == 3'd4) ? 3'd0 : exp_step + 3'd1;
            n_checks++;
            if (bus.STEP !== exp_step || bus.TICK !== 1'b0 || bus.SPEED !== 2'd1) begin
                n_errors++;
                $display("FAIL single_step: pulse %0d got step=%0d tick=%0d speed=%0d expected %0d 0 1", i, bus.STEP, bus.TICK, bus.SPEED, exp_step);
            end
        end
    endtask

    task automatic test_demo_auto();
        int c;
        int nticks;
        logic [2:0] prev;
        logic [2:0] exp_step;
        apply_reset();
        pulse_mode();
        pulse_mode();
        pulse_next();
        n_checks++;
        if (bus.DEMO !== 1'b1 || bus.RUN !== 1'b1 || bus.SPEED !== 2'd0) begin
            n_errors++;
            $display("FAIL demo_entry: got demo=%0d run=%0d speed=%0d expected 1 1 0", bus.DEMO, bus.RUN, bus.SPEED);
        end
        nticks = 0;
        prev   = bus.STEP;
        for (c = 1; c <= 600; c++) begin
            cycle(1);
            if (bus.STEP !== prev) begin
                nticks++;
                exp_step = (prev == 3'd4) ? 3'd0 : prev + 3'd1;
                n_checks++;
                if (bus.STEP !== exp_step) begin
                    n_errors++;
                    $display("FAIL demo_step: tick %0d got %0d expected %0d", nticks, bus.STEP, exp_step);
                end
                prev = bus.STEP;
                if (nticks == 5) begin
                    n_checks++;
                    if (c !== 318 || bus.SPEED !== 2'd1) begin
                        n_errors++;
                        $display("FAIL demo_speed1: got cycle=%0d speed=%0d expected 318 1", c, bus.SPEED);
                    end
                end
                if (nticks == 10) begin
                    n_checks++;
                    if (c !== 478 || bus.SPEED !== 2'd2) begin
                        n_errors++;
                        $display("FAIL demo_speed2: got cycle=%0d speed=%0d expected 478 2", c, bus.SPEED);
                    end
                    break;
                end
            end
        end
        n_checks++;
        if (nticks !== 10) begin
            n_errors++;
            $display("FAIL demo_timeout: got %0d ticks expected 10", nticks);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        pulse_mode();
        pulse_next();
        pulse_both();
        cycle(1);
        n_checks++;
        if (bus.DEMO !== 1'b1 || bus.SPEED !== 2'd1) begin
            n_errors++;
            $display("FAIL simul_run: got demo=%0d speed=%0d expected 1 1", bus.DEMO, bus.SPEED);
        end
        pulse_mode();
        pulse_next();
        n_checks++;
        if (bus.STEP !== 3'd1) begin n_errors++; $display("FAIL simul_stop_step: got %0d expected 1", bus.STEP); end
        pulse_both();
        cycle(1);
        n_checks++;
        if (bus.RUN !== 1'b1 || bus.DEMO !== 1'b0 || bus.STEP !== 3'd1 || bus.SPEED !== 2'd1) begin
            n_errors++;
            $display("FAIL simul_stop: got run=%0d demo=%0d step=%0d speed=%0d expected 1 0 1 1", bus.RUN, bus.DEMO, bus.STEP, bus.SPEED);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        bus.BTN_MODE = 1'b0;
        bus.BTN_NEXT = 1'b0;
        test_reset();
        test_tick_rate();
        test_speed_wrap();
        test_single_step();
        test_demo_auto();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
